// File: rtl/ramd32_fifo_pkg.sv
// Shared sizing constants for the 32-deep distributed-RAM FIFO and its controller.
package ramd32_fifo_pkg;
    localparam int ADDR_W      = 5;
    localparam int PTR_W       = 6;
    localparam int RAM_DEPTH   = 32;
    localparam int LVL_W       = 6;
    localparam int TOTAL_DEPTH = 33;
endpackage

// File: rtl/X_RAMD32.sv
// Behavioural model of a 32x1 distributed RAM cell: synchronous write, asynchronous read.
module X_RAMD32 (
    output logic O,
    input  logic I,
    input  logic CLK,
    input  logic WE,
    input  logic RADR0,
    input  logic RADR1,
    input  logic RADR2,
    input  logic RADR3,
    input  logic RADR4,
    input  logic WADR0,
    input  logic WADR1,
    input  logic WADR2,
    input  logic WADR3,
    input  logic WADR4
);
    logic [31:0] r_mem;
    logic [4:0]  w_radr;
    logic [4:0]  w_wadr;

    assign w_radr = {RADR4, RADR3, RADR2, RADR1, RADR0};
    assign w_wadr = {WADR4, WADR3, WADR2, WADR1, WADR0};
    assign O      = r_mem[w_radr];

    always_ff @(posedge CLK) begin
        if (WE) r_mem[w_wadr] <= I;
    end
endmodule

// File: rtl/ramd32_array.sv
// WIDTH-bit wide, 32-deep RAM built from one X_RAMD32 cell per data bit.
module ramd32_array
    import ramd32_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wadr,
    input  logic [ADDR_W-1:0] i_radr,
    input  logic [WIDTH-1:0]  i_din,
    output logic [WIDTH-1:0]  o_dout
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        X_RAMD32 u_cell (
            .O     (o_dout[g]),
            .I     (i_din[g]),
            .CLK   (i_clk),
            .WE    (i_we),
            .RADR0 (i_radr[0]),
            .RADR1 (i_radr[1]),
            .RADR2 (i_radr[2]),
            .RADR3 (i_radr[3]),
            .RADR4 (i_radr[4]),
            .WADR0 (i_wadr[0]),
            .WADR1 (i_wadr[1]),
            .WADR2 (i_wadr[2]),
            .WADR3 (i_wadr[3]),
            .WADR4 (i_wadr[4])
        );
    end
endmodule

// File: rtl/ramd32_fifo_ctrl.sv
// FIFO sequencer: RAM pointers, first-word-fall-through output register, occupancy and handshakes.
module ramd32_fifo_ctrl
    import ramd32_fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int AFULL_THRESH = 28
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [LVL_W-1:0] o_level,
    output logic             o_empty,
    output logic             o_afull
);
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [LVL_W-1:0] r_level;

    logic [WIDTH-1:0] w_ram_dout;
    logic             w_ram_full;
    logic             w_ram_empty;
    logic             w_wr_acc;
    logic             w_we;
    logic             w_pop;
    logic             w_load;

    assign w_ram_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                         (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign w_ram_empty = (r_wptr == r_rptr);

    // A pop in the same cycle never frees a RAM slot for a write while full.
    assign o_wr_ready = i_rst_n && !w_ram_full;
    assign w_wr_acc   = i_wr_valid && o_wr_ready;
    assign w_we       = w_wr_acc && !i_flush;
    assign w_pop      = r_rd_valid && i_rd_ready;
    assign w_load     = !w_ram_empty && (!r_rd_valid || i_rd_ready);

    ramd32_array #(.WIDTH(WIDTH)) u_array (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_wadr (r_wptr[ADDR_W-1:0]),
        .i_radr (r_rptr[ADDR_W-1:0]),
        .i_din  (i_wr_data),
        .o_dout (w_ram_dout)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_level    <= '0;
        end else if (i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_valid <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PTR_W'(1);
            if (w_load) begin
                r_rd_data  <= w_ram_dout;
                r_rd_valid <= 1'b1;
                r_rptr     <= r_rptr + PTR_W'(1);
            end else if (w_pop) begin
                r_rd_valid <= 1'b0;
            end
            // A prefetch only moves an entry from RAM to the output register.
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_level    = r_level;
    assign o_empty    = (r_level == '0);
    assign o_afull    = (r_level >= LVL_W'(AFULL_THRESH));
endmodule

// File: tb/tb_ramd32_fifo_ctrl.sv
// Directed self-checking bench for ramd32_fifo_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_ramd32_fifo_ctrl;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [5:0] level;
    logic       empty;
    logic       afull;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q[$];

    ramd32_fifo_ctrl #(.WIDTH(8), .AFULL_THRESH(28)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_wr_data  (wr_data),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_level    (level),
        .o_empty    (empty),
        .o_afull    (afull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_checks++;
            if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || level !== 6'd0 || empty !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: wr_ready=%b rd_valid=%b level=%0d empty=%b, want 0 0 0 1",
                         i, wr_ready, rd_valid, level, empty);
            end
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        rst_n = 1'b1; wr_valid = 1'b0;
        next_cycle();
        next_cycle();
        n_checks++;
        if (rd_valid !== 1'b0 || level !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_no_write: rd_valid=%b level=%0d want 0 0", rd_valid, level);
        end
    endtask

    task automatic test_single_write();
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", wr_ready);
        end
        wr_valid = 1'b1; wr_data = 8'hA5;
        next_cycle();
        wr_valid = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || level !== 6'd1) begin
            n_fail++;
            $display("FAIL single_edge1: rd_valid=%b level=%0d want 0 1", rd_valid, level);
        end
        next_cycle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 6'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge2: rd_valid=%b rd_data=%h level=%0d empty=%b want 1 a5 1 0",
                     rd_valid, rd_data, level, empty);
        end
        rd_ready = 1'b1;
        next_cycle();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hA5 || level !== 6'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop: rd_valid=%b rd_data=%h level=%0d empty=%b want 0 a5 0 1",
                     rd_valid, rd_data, level, empty);
        end
    endtask

    task automatic test_fill();
        rd_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            n_checks++;
            if (wr_ready !== 1'b1 || level !== 6'(q.size()) || afull !== (q.size() >= 28)) begin
                n_fail++;
                $display("FAIL fill_step%0d: wr_ready=%b level=%0d afull=%b want 1 %0d %b",
                         i, wr_ready, level, afull, q.size(), (q.size() >= 28));
            end
            wr_valid = 1'b1; wr_data = 8'(i);
            q.push_back(8'(i));
            next_cycle();
        end
        wr_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_ready !== 1'b0 || level !== 6'd33 || afull !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_full%0d: wr_ready=%b level=%0d afull=%b want 0 33 1",
                         i, wr_ready, level, afull);
            end
            next_cycle();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL fill_head: rd_valid=%b rd_data=%h want 1 00", rd_valid, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        rd_ready = 1'b1; wr_valid = 1'b1;
        for (int j = 0; j < 40; j++) begin
            wr_data = 8'(100 + j);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== q[0] || level !== 6'(q.size())) begin
                n_fail++;
                $display("FAIL b2b_out%0d: rd_valid=%b rd_data=%h level=%0d want 1 %h %0d",
                         j, rd_valid, rd_data, level, q[0], q.size());
            end
            if (j > 0) begin
                n_checks++;
                if (wr_ready !== 1'b1 || level !== 6'd32) begin
                    n_fail++;
                    $display("FAIL b2b_rate%0d: wr_ready=%b level=%0d want 1 32", j, wr_ready, level);
                end
            end
            if (wr_ready === 1'b1) q.push_back(wr_data);
            void'(q.pop_front());
            next_cycle();
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
            wr_valid = (sent < 100) && ($urandom_range(3, 0) != 0);
            wr_data  = 8'(sent + 7);
            rd_ready = ($urandom_range(3, 0) != 0);
            n_checks++;
            if (level !== 6'(q.size())) begin
                n_fail++;
                $display("FAIL wrap_level cyc%0d: got %0d want %0d", cyc, level, q.size());
            end
            if (rd_valid && rd_ready) begin
                n_checks++;
                if (q.size() == 0 || rd_data !== q[0]) begin
                    n_fail++;
                    $display("FAIL wrap_data cyc%0d: got %h want %h (model size %0d)",
                             cyc, rd_data, (q.size() != 0) ? q[0] : 8'hxx, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (wr_valid && wr_ready) begin
                q.push_back(wr_data);
                sent++;
            end
            next_cycle();
            cyc++;
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        n_checks++;
        if (cyc >= 3000 || rd_valid !== 1'b0 || level !== 6'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_drain: cyc=%0d rd_valid=%b level=%0d empty=%b want <3000 0 0 1",
                     cyc, rd_valid, level, empty);
        end
    endtask

    task automatic test_flush();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'hC0 + i);
            next_cycle();
        end
        n_checks++;
        if (level !== 6'd10) begin
            n_fail++;
            $display("FAIL flush_pre: level=%0d want 10", level);
        end
        flush = 1'b1; wr_data = 8'h77;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got %b want 1", wr_ready);
        end
        next_cycle();
        flush = 1'b0; wr_valid = 1'b0;
        n_checks++;
        if (level !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: level=%0d empty=%b rd_valid=%b want 0 1 0", level, empty, rd_valid);
        end
        next_cycle();
        next_cycle();
        n_checks++;
        if (rd_valid !== 1'b0 || level !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: rd_valid=%b level=%0d want 0 0", rd_valid, level);
        end
        wr_valid = 1'b1; wr_data = 8'h3C;
        next_cycle();
        wr_valid = 1'b0;
        next_cycle();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C || level !== 6'd1) begin
            n_fail++;
            $display("FAIL flush_after: rd_valid=%b rd_data=%h level=%0d want 1 3c 1", rd_valid, rd_data, level);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
